fir_ctrl_fsm: RTL

FIR_CTRL_FSM -- requirements
Module: fir_ctrl_fsm

---
 rtl/fir_ctrl_fsm_pkg.sv | 85 ++++++++
 rtl/fir_ctrl_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl_fsm_pkg.sv
// Shared types for the FIR control FSM: configuration, engine and streamer
// control/flag bundles, plus the FSM state encoding.
package FIR_package;

    localparam int unsigned LEN_W         = 16;
    localparam int unsigned NB_ITER_PKG_W = 16;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned COEF_W        = 16;
    localparam int unsigned SHIFT_W       = 5;

    typedef logic signed [COEF_W-1:0] coeff_t;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_START,
        FSM_COMPUTE,
        FSM_WAIT,
        FSM_UPDATEIDX,
        FSM_TERMINATE
    } state_fsm_t;

    typedef struct packed {
        logic                     simple_mul;
        logic [SHIFT_W-1:0]       shift;
        logic [LEN_W-1:0]         len;
        coeff_t                   coeff0;
        coeff_t                   coeff1;
        coeff_t                   coeff2;
        coeff_t                   coeff3;
        logic [NB_ITER_PKG_W-1:0] nb_iter;
        logic [ADDR_W-1:0]        a_base;
        logic [ADDR_W-1:0]        b_base;
        logic [ADDR_W-1:0]        stride;
    } ctrl_fsm_t;

    typedef struct packed {
        logic               clear;
        logic               enable;
        logic               start;
        logic               simple_mul;
        logic [SHIFT_W-1:0] shift;
        logic [LEN_W-1:0]   len;
        coeff_t             coeff0;
        coeff_t             coeff1;
        coeff_t             coeff2;
        coeff_t             coeff3;
    } ctrl_engine_t;

    typedef struct packed {
        logic done;
        logic idle;
        logic ready;
    } flags_engine_t;

    typedef struct packed {
        logic              req_start;
        logic [ADDR_W-1:0] base_addr;
        logic [LEN_W-1:0]  trans_size;
    } stream_ctrl_t;

    typedef struct packed {
        stream_ctrl_t source;
        stream_ctrl_t sink;
    } ctrl_streamer_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } stream_flags_t;

    typedef struct packed {
        stream_flags_t source;
        stream_flags_t sink;
    } flags_streamer_t;

    // Vector lengths above the hardware maximum are clamped at latch time.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned max_len);
        if (32'(len) > max_len) begin
            return LEN_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/fir_ctrl_fsm.sv
// Iteration controller for the FIR engine and its source/sink streamers.
// Optional build macro FIR_CTRL_FSM_PERF_CNT_EN adds a busy-cycle counter on perf_cnt_o.
module fir_ctrl_fsm
    import FIR_package::*;
#(
    parameter int unsigned FIR_CNT_LEN = 1024,
    parameter int unsigned NB_ITER_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 trigger_i,
    input  ctrl_fsm_t            ctrl_i,
    input  flags_engine_t        flags_engine_i,
    input  flags_streamer_t      flags_streamer_i,
    output ctrl_engine_t         ctrl_engine_o,
    output ctrl_streamer_t       ctrl_streamer_o,
    output logic                 busy_o,
    output logic                 done_o,
`ifdef FIR_CTRL_FSM_PERF_CNT_EN
    output logic [31:0]          perf_cnt_o,
`endif
    output logic [NB_ITER_W-1:0] iter_o
);

    state_fsm_t               state_q, state_d;
    ctrl_fsm_t                cfg_q, cfg_d;
    logic [NB_ITER_PKG_W-1:0] iter_q, iter_d;
    logic [ADDR_W-1:0]        a_addr_q, a_addr_d;
    logic [ADDR_W-1:0]        b_addr_q, b_addr_d;
    logic                     entry_q, entry_d;

    logic soft_rst;
    logic all_ready;
    logic last_iter;
    logic go_start;
    logic enable_c;
    logic done_c;

    assign soft_rst  = rst_i | clear_i;
    assign all_ready = flags_streamer_i.source.ready_start
                     & flags_streamer_i.sink.ready_start
                     & flags_engine_i.ready;
    assign last_iter = (iter_q == (cfg_q.nb_iter - NB_ITER_PKG_W'(1)));

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q  <= FSM_IDLE;
            cfg_q    <= '0;
            iter_q   <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            entry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            iter_q   <= iter_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            entry_q  <= entry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        iter_d   = iter_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        entry_d  = 1'b0;
        go_start = 1'b0;
        enable_c = 1'b0;
        done_c   = 1'b0;

        unique case (state_q)
            FSM_IDLE: begin
                if (trigger_i) begin
                    cfg_d     = ctrl_i;
                    cfg_d.len = clamp_len(ctrl_i.len, FIR_CNT_LEN);
                    iter_d    = '0;
                    a_addr_d  = ctrl_i.a_base;
                    b_addr_d  = ctrl_i.b_base;
                    if (ctrl_i.nb_iter == '0) begin
                        state_d = FSM_TERMINATE;
                    end else begin
                        state_d = FSM_START;
                        entry_d = 1'b1;
                    end
                end
            end
            // The entry cycle is reserved for the engine clear pulse.
            FSM_START: begin
                if (!entry_q && all_ready) begin
                    go_start = 1'b1;
                    state_d  = FSM_COMPUTE;
                end
            end
            FSM_COMPUTE: begin
                enable_c = 1'b1;
                if (flags_engine_i.done) begin
                    state_d = flags_streamer_i.sink.done ? FSM_UPDATEIDX : FSM_WAIT;
                end
            end
            FSM_WAIT: begin
                if (flags_streamer_i.sink.done) begin
                    state_d = FSM_UPDATEIDX;
                end
            end
            FSM_UPDATEIDX: begin
                if (last_iter) begin
                    state_d = FSM_TERMINATE;
                end else begin
                    iter_d   = iter_q + NB_ITER_PKG_W'(1);
                    a_addr_d = a_addr_q + cfg_q.stride;
                    b_addr_d = b_addr_q + cfg_q.stride;
                    state_d  = FSM_START;
                    entry_d  = 1'b1;
                end
            end
            FSM_TERMINATE: begin
                done_c  = 1'b1;
                state_d = FSM_IDLE;
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_comb begin
        ctrl_engine_o.clear      = soft_rst | entry_q;
        ctrl_engine_o.enable     = enable_c & ~soft_rst;
        ctrl_engine_o.start      = go_start & ~soft_rst;
        ctrl_engine_o.simple_mul = cfg_q.simple_mul;
        ctrl_engine_o.shift      = cfg_q.shift;
        ctrl_engine_o.len        = cfg_q.len;
        ctrl_engine_o.coeff0     = cfg_q.coeff0;
        ctrl_engine_o.coeff1     = cfg_q.coeff1;
        ctrl_engine_o.coeff2     = cfg_q.coeff2;
        ctrl_engine_o.coeff3     = cfg_q.coeff3;

        ctrl_streamer_o.source.req_start  = go_start & ~soft_rst;
        ctrl_streamer_o.source.base_addr  = a_addr_q;
        ctrl_streamer_o.source.trans_size = cfg_q.len;
        ctrl_streamer_o.sink.req_start    = go_start & ~soft_rst;
        ctrl_streamer_o.sink.base_addr    = b_addr_q;
        ctrl_streamer_o.sink.trans_size   = cfg_q.len;
    end

    assign busy_o = (state_q != FSM_IDLE);
    assign done_o = done_c & ~soft_rst;
    assign iter_o = NB_ITER_W'(iter_q);

    // Base addresses only seed the running addresses; idle/source-done are not needed.
    logic unused_bits;
    assign unused_bits = ^{cfg_q.a_base, cfg_q.b_base,
                           flags_engine_i.idle, flags_streamer_i.source.done};

`ifdef FIR_CTRL_FSM_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            perf_cnt_q <= '0;
        end else if (state_q == FSM_IDLE && trigger_i) begin
            perf_cnt_q <= '0;
        end else if (busy_o && perf_cnt_q != '1) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_cnt_o = perf_cnt_q;
`endif

endmodule
